// File: rtl/pc_ir_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_ir_fetch_unit_if : controller <-> fetch-unit signal bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pc_ir_fetch_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] mem_data_in;
  logic              ir_write_part1;
  logic              ir_write_part2;
  logic              pc_write;
  logic              pc_data_sel;
  logic              di_write;

  logic [ADDR_W-1:0] pc;
  logic [3:0]        upcode;
  logic [ADDR_W-1:0] ir_address;
  logic [1:0]        reg_i;
  logic [1:0]        reg_j;
  logic [DATA_W-1:0] di_out;
  logic              addr_valid;
  logic              seq_error;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output mem_data_in, ir_write_part1, ir_write_part2, pc_write, pc_data_sel, di_write,
    input  pc, upcode, ir_address, reg_i, reg_j, di_out, addr_valid, seq_error, instr_count
  );

  modport slave (
    input  mem_data_in, ir_write_part1, ir_write_part2, pc_write, pc_data_sel, di_write,
    output pc, upcode, ir_address, reg_i, reg_j, di_out, addr_valid, seq_error, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_ir_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_ir_fetch_unit : PC, two-byte IR, DI register and fetch-sequence checker
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_ir_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire                  clk,
  input  wire                  rst,
  pc_ir_fetch_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    WAIT_OP   = 2'd0,
    HAVE_OP   = 2'd1,
    HAVE_ADDR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir1_q, ir1_d;
  logic [DATA_W-1:0] ir2_q, ir2_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              av_q, av_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic p1_w, p2_w;
  assign p1_w = bus.ir_write_part1;
  assign p2_w = bus.ir_write_part2;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    di_d    = di_q;
    av_d    = av_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // Jump target and DI use the IR1 already held, never the byte arriving now.
    if (bus.pc_write) begin
      if (bus.pc_data_sel)
        pc_d = {pc_q[ADDR_W-1:4], ir1_q[3:0]};
      else
        pc_d = pc_q + ADDR_W'(1);
    end

    if (bus.di_write)
      di_d = {{(DATA_W-4){1'b0}}, ir1_q[3:0]};

    if (p1_w && p2_w) begin
      err_d = 1'b1;
    end else if (p1_w) begin
      ir1_d   = bus.mem_data_in;
      av_d    = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = HAVE_OP;
    end else if (p2_w) begin
      ir2_d = bus.mem_data_in;
      av_d  = 1'b1;
      // Address byte is only legal right after an opcode of the addressed class.
      if (state_q != HAVE_OP || ir1_q[DATA_W-1])
        err_d = 1'b1;
      if (state_q == HAVE_OP)
        state_d = HAVE_ADDR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_OP;
      pc_q    <= RESET_PC;
      ir1_q   <= '0;
      ir2_q   <= '0;
      di_q    <= '0;
      av_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      di_q    <= di_d;
      av_q    <= av_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.upcode      = ir1_q[DATA_W-1:DATA_W-4];
  assign bus.ir_address  = ADDR_W'({ir1_q[3:0], ir2_q});
  assign bus.reg_i       = ir1_q[3:2];
  assign bus.reg_j       = ir1_q[1:0];
  assign bus.di_out      = di_q;
  assign bus.addr_valid  = av_q;
  assign bus.seq_error   = err_q;
  assign bus.instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ir_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_ir_fetch_unit : scoreboard bench with a behavioural fetch model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pc_ir_fetch_unit;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_ir_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  pc_ir_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_PC(12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  upcode;
    logic [11:0] ira;
    logic [1:0]  ri;
    logic [1:0]  rj;
    logic [7:0]  di;
    logic        av;
    logic        err;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;
  event ev_async;

  // Reference state: architectural registers plus "opcode byte seen, address byte not yet"
  logic [11:0] m_pc;
  logic [7:0]  m_ir1, m_ir2, m_di;
  logic        m_av, m_err, m_mid;
  int          m_cnt;

  function automatic exp_t snap(string tag);
    exp_t e;
    e.pc     = m_pc;
    e.upcode = m_ir1[7:4];
    e.ira    = {m_ir1[3:0], m_ir2};
    e.ri     = m_ir1[3:2];
    e.rj     = m_ir1[1:0];
    e.di     = m_di;
    e.av     = m_av;
    e.err    = m_err;
    e.cnt    = 16'(m_cnt % 65536);
    e.tag    = tag;
    return e;
  endfunction

  task automatic chk(string name, string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s] actual=%0h required=%0h", name, tag, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or ev_async);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",          e.tag, 32'(bus.pc),          32'(e.pc));
        chk("upcode",      e.tag, 32'(bus.upcode),      32'(e.upcode));
        chk("ir_address",  e.tag, 32'(bus.ir_address),  32'(e.ira));
        chk("reg_i",       e.tag, 32'(bus.reg_i),       32'(e.ri));
        chk("reg_j",       e.tag, 32'(bus.reg_j),       32'(e.rj));
        chk("di_out",      e.tag, 32'(bus.di_out),      32'(e.di));
        chk("addr_valid",  e.tag, 32'(bus.addr_valid),  32'(e.av));
        chk("seq_error",   e.tag, 32'(bus.seq_error),   32'(e.err));
        chk("instr_count", e.tag, 32'(bus.instr_count), 32'(e.cnt));
      end
    end
  end

  task automatic drive_idle();
    bus.mem_data_in    = '0;
    bus.ir_write_part1 = 1'b0;
    bus.ir_write_part2 = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_data_sel    = 1'b0;
    bus.di_write       = 1'b0;
  endtask

  task automatic step(bit p1, bit p2, bit pw, bit sel, bit dw, logic [7:0] d, string tag);
    logic [7:0] old_ir1;
    bus.ir_write_part1 = p1;
    bus.ir_write_part2 = p2;
    bus.pc_write       = pw;
    bus.pc_data_sel    = sel;
    bus.di_write       = dw;
    bus.mem_data_in    = d;
    @(posedge clk);
    old_ir1 = m_ir1;
    if (pw) m_pc = sel ? {m_pc[11:4], old_ir1[3:0]} : 12'((int'(m_pc) + 1) % 4096);
    if (dw) m_di = {4'h0, old_ir1[3:0]};
    if (p1 && p2) begin
      m_err = 1'b1;
    end else if (p1) begin
      m_ir1 = d; m_av = 1'b0; m_cnt = m_cnt + 1; m_mid = 1'b1;
    end else if (p2) begin
      if (!m_mid || old_ir1[7]) m_err = 1'b1;
      m_ir2 = d; m_av = 1'b1; m_mid = 1'b0;
    end
    q.push_back(snap(tag));
    #1;
  endtask

  // Reset lands between clock edges and is checked before any edge follows.
  task automatic do_reset(string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    drive_idle();
    m_pc = 12'h000; m_ir1 = 8'h00; m_ir2 = 8'h00; m_di = 8'h00;
    m_av = 1'b0; m_err = 1'b0; m_mid = 1'b0; m_cnt = 0;
    #1;
    q.push_back(snap(tag));
    -> ev_async;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic finish_run();
    if (!done) begin
      done = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    finish_run();
  end

  initial begin : stimulus
    drive_idle();
    #2;

    // Two-byte fetch of an addressed instruction
    do_reset("t1_reset");
    step(1, 0, 1, 0, 0, 8'h05, "t1_part1");
    step(0, 0, 0, 0, 0, 8'h00, "t1_idle");
    step(0, 1, 1, 0, 0, 8'h3C, "t1_part2");

    // Field decode and page-relative jump
    do_reset("t2_reset");
    step(1, 0, 0, 0, 0, 8'h96, "t2_decode");
    while (m_pc != 12'h123) step(0, 0, 1, 0, 0, 8'h00, "t2_walk");
    step(1, 0, 0, 0, 0, 8'hC7, "t2_ir1");
    step(0, 0, 1, 1, 0, 8'h00, "t2_jump");

    // PC wrap and counter wrap
    while (m_pc != 12'hFFF) step(0, 0, 1, 0, 0, 8'h00, "t3_walk");
    step(0, 0, 1, 0, 0, 8'h00, "t3_pc_wrap");
    do_reset("t3_reset");
    for (int i = 0; i < 65536; i++) step(1, 0, 0, 0, 0, 8'($urandom), "t3_cnt");

    // DI load and hold
    do_reset("t4_reset");
    step(1, 0, 0, 0, 0, 8'hDA, "t4_ir1");
    step(0, 0, 0, 0, 1, 8'h00, "t4_di_load");
    step(1, 0, 0, 0, 0, 8'h31, "t4_ir1b");
    step(0, 0, 0, 0, 0, 8'h00, "t4_di_hold");

    // Protocol violations
    do_reset("t5a_reset");
    step(0, 1, 0, 0, 0, 8'h55, "t5a_part2_first");
    do_reset("t5b_reset");
    step(1, 0, 0, 0, 0, 8'h12, "t5b_p1");
    step(0, 1, 0, 0, 0, 8'h34, "t5b_p2");
    step(1, 1, 0, 0, 0, 8'hAB, "t5b_both");
    do_reset("t5c_reset");
    step(1, 0, 0, 0, 0, 8'h80, "t5c_p1");
    step(0, 1, 0, 0, 0, 8'h77, "t5c_p2_nodata");
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 0, 8'($urandom_range(0, 127)), "t5d_sticky_p1");
      step(0, 1, 1, 0, 0, 8'($urandom), "t5d_sticky_p2");
    end

    // Asynchronous reset mid-instruction
    do_reset("t6_reset");
    step(1, 0, 1, 0, 0, 8'h2F, "t6_sta_p1");
    do_reset("t6_async");
    step(0, 1, 0, 0, 0, 8'h40, "t6_orphan_p2");

    // Randomized traffic
    do_reset("rnd_reset");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rnd_async");
      end else begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
             8'($urandom), "rnd");
      end
    end

    step(0, 0, 0, 0, 0, 8'h00, "final_idle");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    finish_run();
  end
endmodule
`default_nettype wire
